// File: rtl/arith_pkg.sv
// Shared types for the arithmetic group (CLAA adder and its divider companion).
// Contents:
//   div_state_t : handshake/iteration state of the sequential divider.
package arith_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_CALC,
      DIV_DONE
   } div_state_t;

endpackage : arith_pkg

// File: rtl/claa.sv
// Carry-lookahead adder: s_o = a_i + b_i + c_i over WORD_WIDTH bits.
// Ports:
//   a_i, b_i : addends (WORD_WIDTH bits)
//   c_i      : carry in
//   s_o      : sum (WORD_WIDTH bits)
//   c_o      : carry out of the MSB
//   p_o      : group propagate (all bit propagates set)
//   g_o      : group generate (carry produced independent of c_i)
module claa #(
   parameter int WORD_WIDTH = 8
) (
   input  logic [WORD_WIDTH-1:0] a_i,
   input  logic [WORD_WIDTH-1:0] b_i,
   input  logic                  c_i,
   output logic [WORD_WIDTH-1:0] s_o,
   output logic                  c_o,
   output logic                  p_o,
   output logic                  g_o
);

   logic [WORD_WIDTH-1:0] prop;
   logic [WORD_WIDTH-1:0] gen;
   logic [WORD_WIDTH:0]   carry;
   logic                  grp_gen;

   assign prop = a_i ^ b_i;
   assign gen  = a_i & b_i;

   always_comb begin
      carry    = '0;
      carry[0] = c_i;
      grp_gen  = 1'b0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         carry[i+1] = gen[i] | (prop[i] & carry[i]);
         grp_gen    = gen[i] | (prop[i] & grp_gen);
      end
   end

   assign s_o = prop ^ carry[WORD_WIDTH-1:0];
   assign c_o = carry[WORD_WIDTH];
   assign p_o = &prop;
   assign g_o = grp_gen;

endmodule : claa

// File: rtl/claa_divider_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Each trial subtraction rem - divisor is formed as rem + ~divisor + 1 on a
// CLAA one bit wider than the operands; its carry out means "no borrow".
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   valid_i/ready_o            : operand handshake (ready_o high in IDLE)
//   dividend_i, divisor_i      : unsigned operands, sampled at accept
//   valid_o/ready_i            : result handshake (valid_o high in DONE)
//   quotient_o, remainder_o    : result, updated only on entering DONE
//   div_by_zero_o              : divisor was zero for the current result
module claa_divider_seq
   import arith_pkg::*;
#(
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [WORD_WIDTH-1:0] dividend_i,
   input  logic [WORD_WIDTH-1:0] divisor_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [WORD_WIDTH-1:0] quotient_o,
   output logic [WORD_WIDTH-1:0] remainder_o,
   output logic                  div_by_zero_o
);

   localparam int CNT_W = $clog2(WORD_WIDTH);

   div_state_t            state;
   div_state_t            state_next;
   logic [WORD_WIDTH:0]   rem;
   logic [WORD_WIDTH-1:0] quo;
   logic [WORD_WIDTH-1:0] dsr;
   logic [CNT_W-1:0]      count;

   logic [WORD_WIDTH:0]   rem_shift;
   logic [WORD_WIDTH:0]   trial;
   logic [WORD_WIDTH:0]   rem_step;
   logic [WORD_WIDTH-1:0] quo_step;
   logic                  no_borrow;
   logic                  rem_msb_unused;

   // The quotient register doubles as the dividend shift register: its MSB
   // feeds the remainder LSB while the new quotient bit enters at the bottom.
   assign rem_shift = {rem[WORD_WIDTH-1:0], quo[WORD_WIDTH-1]};
   assign quo_step  = {quo[WORD_WIDTH-2:0], no_borrow};
   assign rem_step  = no_borrow ? trial : rem_shift;

   // rem stays below the divisor, so its top bit is always zero between steps.
   assign rem_msb_unused = rem[WORD_WIDTH] & rem_step[WORD_WIDTH];

   claa #(
      .WORD_WIDTH(WORD_WIDTH + 1)
   ) u_claa (
      .a_i (rem_shift),
      .b_i (~{1'b0, dsr}),
      .c_i (1'b1),
      .s_o (trial),
      .c_o (no_borrow),
      .p_o (),
      .g_o ()
   );

   assign ready_o = (state == DIV_IDLE);
   assign valid_o = (state == DIV_DONE);

   always_comb begin
      state_next = state;
      case (state)
         DIV_IDLE: if (valid_i) state_next = (divisor_i == '0) ? DIV_DONE : DIV_CALC;
         DIV_CALC: if (count == '0) state_next = DIV_DONE;
         DIV_DONE: if (ready_i) state_next = DIV_IDLE;
         default:  state_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= DIV_IDLE;
         quotient_o    <= '0;
         remainder_o   <= '0;
         div_by_zero_o <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            DIV_IDLE: begin
               if (valid_i) begin
                  quo   <= dividend_i;
                  dsr   <= divisor_i;
                  rem   <= '0;
                  count <= CNT_W'(WORD_WIDTH - 1);
                  if (divisor_i == '0) begin
                     quotient_o    <= '1;
                     remainder_o   <= dividend_i;
                     div_by_zero_o <= 1'b1;
                  end
               end
            end
            DIV_CALC: begin
               rem <= rem_step;
               quo <= quo_step;
               if (count == '0) begin
                  quotient_o    <= quo_step;
                  remainder_o   <= rem_step[WORD_WIDTH-1:0];
                  div_by_zero_o <= 1'b0;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : claa_divider_seq
